// File: rtl/wdt_counter_pkg.sv
// wdt_counter_pkg: shared WDT parameters and state encodings
package wdt_counter_pkg;

    localparam int WDT_DEF_CNT_WIDTH = 32;
    localparam int WDT_RPL_WIDTH     = 8;

    typedef enum logic [1:0] {
        WDT_IDLE  = 2'd0,
        WDT_COUNT = 2'd1,
        WDT_INTP  = 2'd2,
        WDT_RSTP  = 2'd3
    } wdt_state_e;

endpackage

// File: rtl/wdt_counter_rst_pulse.sv
// wdt_rst_pulse: loadable down-counter producing a registered len+1 cycle reset pulse
module wdt_rst_pulse
    import wdt_counter_pkg::*;
(
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     start,
    input  logic [WDT_RPL_WIDTH-1:0] len,
    output logic                     pulse
);

    logic                     active_q, active_d;
    logic [WDT_RPL_WIDTH-1:0] left_q, left_d;

    // start arms the pulse with len remaining; it drops once the count is exhausted
    always_comb begin
        active_d = active_q;
        left_d   = left_q;
        if (start) begin
            active_d = 1'b1;
            left_d   = len;
        end else if (active_q) begin
            if (left_q == '0) active_d = 1'b0;
            else left_d = left_q - WDT_RPL_WIDTH'(1);
        end
    end

    // pulse state register
    always_ff @(posedge pclk) begin
        if (preset) begin
            active_q <= 1'b0;
            left_q   <= '0;
        end else begin
            active_q <= active_d;
            left_q   <= left_d;
        end
    end

    assign pulse = active_q;

endmodule

// File: rtl/wdt_counter.sv
// wdt_counter: watchdog down-counter with interrupt-then-reset response
module wdt_counter
    import wdt_counter_pkg::*;
#(
    parameter int WDT_CNT_WIDTH = WDT_DEF_CNT_WIDTH
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     clk_en,
    input  logic                     wdt_en,
    input  logic [WDT_CNT_WIDTH-1:0] top,
    input  logic                     restart,
    input  logic                     eoi_en,
    input  logic                     rmod,
    input  logic [WDT_RPL_WIDTH-1:0] rpl,
    output logic [WDT_CNT_WIDTH-1:0] cnt,
    output logic                     wdt_int,
    output logic                     wdt_sys_rst
);

    wdt_state_e               state_q, state_d;
    logic [WDT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     int_q, int_d;
    logic                     start;
    logic                     pulse;
    logic                     timeout;

    assign timeout = clk_en && (cnt_q == '0);

    wdt_rst_pulse u_rst_pulse (
        .pclk   (pclk),
        .preset (preset),
        .start  (start),
        .len    (rpl),
        .pulse  (pulse)
    );

    // next state: disable beats restart beats eoi beats timeout; the counter never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        int_d   = int_q;
        start   = 1'b0;
        case (state_q)
            WDT_IDLE: begin
                if (wdt_en) begin
                    cnt_d   = top;
                    state_d = WDT_COUNT;
                end
            end
            WDT_COUNT, WDT_INTP: begin
                if (!wdt_en) begin
                    int_d   = 1'b0;
                    state_d = WDT_IDLE;
                end else if (restart) begin
                    cnt_d   = top;
                    int_d   = 1'b0;
                    state_d = WDT_COUNT;
                end else if (state_q == WDT_INTP && eoi_en) begin
                    int_d   = 1'b0;
                    state_d = WDT_COUNT;
                    if (clk_en && cnt_q != '0) cnt_d = cnt_q - WDT_CNT_WIDTH'(1);
                end else if (timeout) begin
                    if (state_q == WDT_COUNT && rmod) begin
                        int_d   = 1'b1;
                        cnt_d   = top;
                        state_d = WDT_INTP;
                    end else begin
                        start   = 1'b1;
                        state_d = WDT_RSTP;
                    end
                end else if (clk_en) begin
                    cnt_d = cnt_q - WDT_CNT_WIDTH'(1);
                end
            end
            WDT_RSTP: begin
                if (!pulse) begin
                    int_d   = 1'b0;
                    cnt_d   = top;
                    state_d = wdt_en ? WDT_COUNT : WDT_IDLE;
                end
            end
            default: state_d = WDT_IDLE;
        endcase
    end

    // state, count and interrupt registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= WDT_IDLE;
            cnt_q   <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
        end
    end

    assign cnt         = cnt_q;
    assign wdt_int     = int_q;
    assign wdt_sys_rst = pulse;

endmodule

// File: tb/tb_wdt_counter.sv
// tb_wdt_counter: directed self-checking bench for wdt_counter
module tb_wdt_counter;
    import wdt_counter_pkg::*;

    logic        pclk = 1'b0;
    logic        preset, clk_en, wdt_en, restart, eoi_en, rmod;
    logic [15:0] top;
    logic [7:0]  rpl;
    logic [15:0] cnt;
    logic        wdt_int, wdt_sys_rst;

    int checks = 0;
    int errors = 0;

    wdt_counter #(.WDT_CNT_WIDTH(16)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .clk_en      (clk_en),
        .wdt_en      (wdt_en),
        .top         (top),
        .restart     (restart),
        .eoi_en      (eoi_en),
        .rmod        (rmod),
        .rpl         (rpl),
        .cnt         (cnt),
        .wdt_int     (wdt_int),
        .wdt_sys_rst (wdt_sys_rst)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        preset  = 1'b1;
        wdt_en  = 1'b0;
        clk_en  = 1'b1;
        restart = 1'b0;
        eoi_en  = 1'b0;
        tick();
        preset = 1'b0;
    endtask

    task automatic run_to_zero(input int n);
        for (int i = n - 1; i >= 0; i--) begin
            tick();
            check("countdown", 32'(cnt), 32'(i));
        end
    endtask

    int rst_cyc;
    int int_seen;
    logic [15:0] exp_cnt;

    initial begin
        top = 16'd4; rmod = 1'b0; rpl = 8'd3;
        do_reset();
        check("rst_cnt", 32'(cnt), 0);
        check("rst_int", 32'(wdt_int), 0);
        check("rst_sys", 32'(wdt_sys_rst), 0);
        check("rst_state", 32'(dut.state_q), 32'(WDT_IDLE));

        // plain timeout to reset, rpl=3
        wdt_en = 1'b1;
        tick();
        check("t1_load", 32'(cnt), 4);
        run_to_zero(4);
        tick();
        check("t1_rst_rise", 32'(wdt_sys_rst), 1);
        rst_cyc = 1; int_seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            rst_cyc += int'(wdt_sys_rst);
            int_seen += int'(wdt_int);
        end
        check("t1_rst_len", 32'(rst_cyc), 4);
        check("t1_no_int", 32'(int_seen), 0);

        // interrupt then reset, rpl=0
        rmod = 1'b1; rpl = 8'd0;
        do_reset();
        wdt_en = 1'b1;
        tick();
        run_to_zero(4);
        tick();
        check("t2_int", 32'(wdt_int), 1);
        check("t2_reload", 32'(cnt), 4);
        check("t2_rst_low", 32'(wdt_sys_rst), 0);
        run_to_zero(4);
        check("t2_int_hold", 32'(wdt_int), 1);
        tick();
        check("t2_rst_rise", 32'(wdt_sys_rst), 1);
        check("t2_int_in_rst", 32'(wdt_int), 1);
        tick();
        check("t2_rst_fall", 32'(wdt_sys_rst), 0);
        tick();
        check("t2_int_clr", 32'(wdt_int), 0);
        check("t2_reload2", 32'(cnt), 4);
        check("t2_state", 32'(dut.state_q), 32'(WDT_COUNT));

        // eoi rescue
        do_reset();
        wdt_en = 1'b1;
        tick();
        run_to_zero(4);
        tick();
        check("t3_int", 32'(wdt_int), 1);
        tick();
        tick();
        check("t3_cnt2", 32'(cnt), 2);
        eoi_en = 1'b1;
        tick();
        eoi_en = 1'b0;
        check("t3_int_clr", 32'(wdt_int), 0);
        check("t3_cnt1", 32'(cnt), 1);
        tick();
        check("t3_cnt0", 32'(cnt), 0);
        tick();
        check("t3_reint", 32'(wdt_int), 1);
        check("t3_no_rst", 32'(wdt_sys_rst), 0);
        check("t3_reload", 32'(cnt), 4);

        // restart races timeout
        rmod = 1'b0;
        do_reset();
        wdt_en = 1'b1;
        tick();
        run_to_zero(4);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("t4_reload", 32'(cnt), 4);
        check("t4_no_int", 32'(wdt_int), 0);
        check("t4_no_rst", 32'(wdt_sys_rst), 0);
        tick();
        check("t4_next", 32'(cnt), 3);
        check("t4_no_rst2", 32'(wdt_sys_rst), 0);

        // clk_en gating, one enable every 4th cycle
        top = 16'd3;
        do_reset();
        clk_en = 1'b0;
        wdt_en = 1'b1;
        tick();
        check("t5_load", 32'(cnt), 3);
        exp_cnt = 16'd3;
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < 3; j++) tick();
            check("t5_hold", 32'(cnt), 32'(exp_cnt));
            check("t5_rst_pre", 32'(wdt_sys_rst), 0);
            clk_en = 1'b1;
            tick();
            clk_en = 1'b0;
            if (k < 4) begin
                exp_cnt = exp_cnt - 16'd1;
                check("t5_dec", 32'(cnt), 32'(exp_cnt));
            end else begin
                check("t5_timeout", 32'(wdt_sys_rst), 1);
            end
        end

        // reset applied mid-pulse, rpl=255
        top = 16'd2; rpl = 8'd255;
        do_reset();
        wdt_en = 1'b1;
        tick();
        run_to_zero(2);
        tick();
        rst_cyc = int'(wdt_sys_rst);
        for (int i = 0; i < 8; i++) begin
            tick();
            rst_cyc += int'(wdt_sys_rst);
        end
        check("t6_pulse9", 32'(rst_cyc), 9);
        tick();
        check("t6_pulse10", 32'(wdt_sys_rst), 1);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        wdt_en = 1'b0;
        check("t6_rst_off", 32'(wdt_sys_rst), 0);
        check("t6_cnt", 32'(cnt), 0);
        check("t6_state", 32'(dut.state_q), 32'(WDT_IDLE));
        tick();
        check("t6_stay_idle", 32'(dut.state_q), 32'(WDT_IDLE));
        check("t6_rst_stays", 32'(wdt_sys_rst), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
